// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: tracks in-flight writers over DEPTH post-issue stages,
// selects the youngest producer per source operand and raises a load-use stall.
module fwd_bypass_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    iss_valid,
  input  logic                                    iss_we,
  input  logic                                    iss_load,
  input  logic [REG_ADDR-1:0]                     iss_rd,
  input  logic [NUM_SRC*REG_ADDR-1:0]             iss_rs,
  input  logic [NUM_SRC*WIDTH-1:0]                rf_data,
  input  logic [WIDTH-1:0]                        ex_data,
  input  logic [WIDTH-1:0]                        mem_data,
  input  logic                                    flush,
  output logic [NUM_SRC*WIDTH-1:0]                opnd,
  output logic [NUM_SRC*$clog2(DEPTH+2)-1:0]      fwd_sel,
  output logic                                    stall,
  output logic [CNT_W-1:0]                        fwd_hits,
  output logic [CNT_W-1:0]                        stall_cyc
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 2);
  localparam int unsigned HC_W  = $clog2(NUM_SRC + 1);
  localparam int unsigned CW1   = CNT_W + 1;

  logic                s_valid [DEPTH];
  logic [REG_ADDR-1:0] s_rd    [DEPTH];
  logic                s_load  [DEPTH];
  logic                s_ready [DEPTH];
  logic [WIDTH-1:0]    s_data  [DEPTH];

  logic                load_hit;
  logic                accept;
  logic [HC_W-1:0]     hit_cnt;
  logic [REG_ADDR-1:0] cur_rs;
  logic [WIDTH-1:0]    cur_val;
  logic [SEL_W-1:0]    cur_sel;
  logic [CW1-1:0]      hits_sum;
  logic [CNT_W-1:0]    hits_next;

  // Per-source select: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    opnd     = '0;
    fwd_sel  = '0;
    load_hit = 1'b0;
    hit_cnt  = '0;
    cur_rs   = '0;
    cur_val  = '0;
    cur_sel  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      cur_rs  = iss_rs[i*REG_ADDR +: REG_ADDR];
      cur_val = rf_data[i*WIDTH +: WIDTH];
      cur_sel = '0;
      if (cur_rs == '0) begin
        cur_val = '0;
        cur_sel = SEL_W'(DEPTH + 1);
      end else begin
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
          if (s_valid[k] && (s_rd[k] == cur_rs)) begin
            if ((k == 0) && s_load[0]) begin
              load_hit = 1'b1;
            end else begin
              cur_sel = SEL_W'(k + 1);
              if (k == 0)           cur_val = ex_data;
              else if (!s_ready[k]) cur_val = mem_data;
              else                  cur_val = s_data[k];
            end
          end
        end
      end
      if ((cur_sel != '0) && (cur_sel != SEL_W'(DEPTH + 1)))
        hit_cnt = hit_cnt + HC_W'(1);
      opnd[i*WIDTH +: WIDTH]    = cur_val;
      fwd_sel[i*SEL_W +: SEL_W] = cur_sel;
    end
  end

  assign stall  = iss_valid & ~flush & load_hit;
  assign accept = iss_valid & ~stall & ~flush & ~reset;

  // Saturating hit counter update; a single cycle may add several hits.
  always_comb begin
    hits_sum  = CW1'(fwd_hits) + CW1'(hit_cnt);
    hits_next = hits_sum[CNT_W] ? '1 : hits_sum[CNT_W-1:0];
  end

  // Stage advance: the pipeline never freezes, a stall simply inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        s_valid[k] <= 1'b0;
        s_load[k]  <= 1'b0;
        s_ready[k] <= 1'b0;
        s_rd[k]    <= '0;
        s_data[k]  <= '0;
      end
      fwd_hits  <= '0;
      stall_cyc <= '0;
    end else begin
      s_valid[0] <= accept & iss_we;
      s_rd[0]    <= iss_rd;
      s_load[0]  <= accept & iss_load;
      s_ready[0] <= 1'b0;
      s_data[0]  <= '0;

      s_valid[1] <= s_valid[0];
      s_rd[1]    <= s_rd[0];
      s_load[1]  <= s_load[0];
      s_ready[1] <= ~s_load[0];
      s_data[1]  <= s_load[0] ? s_data[0] : ex_data;

      for (int k = 2; k < int'(DEPTH); k++) begin
        s_valid[k] <= s_valid[k-1];
        s_rd[k]    <= s_rd[k-1];
        s_load[k]  <= s_load[k-1];
        s_ready[k] <= 1'b1;
        s_data[k]  <= s_ready[k-1] ? s_data[k-1] : mem_data;
      end

      if (accept)
        fwd_hits <= hits_next;
      if (stall && (stall_cyc != '1))
        stall_cyc <= stall_cyc + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Directed-vector bench for fwd_bypass_unit (DEPTH=3, NUM_SRC=2, CNT_W=4).
module tb_fwd_bypass_unit;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_ADDR = 5;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned NUM_SRC  = 2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SEL_W    = 3;
  localparam logic [31:0] RF0      = 32'hAAAA_0000;
  localparam logic [31:0] RF1      = 32'hBBBB_0000;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        iss_valid, iss_we, iss_load, flush;
  logic [REG_ADDR-1:0]         iss_rd;
  logic [NUM_SRC*REG_ADDR-1:0] iss_rs;
  logic [NUM_SRC*WIDTH-1:0]    rf_data;
  logic [WIDTH-1:0]            ex_data, mem_data;
  logic [NUM_SRC*WIDTH-1:0]    opnd;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall;
  logic [CNT_W-1:0]            fwd_hits, stall_cyc;

  int vectors = 0;
  int errors  = 0;

  fwd_bypass_unit #(
    .WIDTH(WIDTH), .REG_ADDR(REG_ADDR), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_we(iss_we), .iss_load(iss_load),
    .iss_rd(iss_rd), .iss_rs(iss_rs), .rf_data(rf_data), .ex_data(ex_data),
    .mem_data(mem_data), .flush(flush), .opnd(opnd), .fwd_sel(fwd_sel), .stall(stall),
    .fwd_hits(fwd_hits), .stall_cyc(stall_cyc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one issue slot, then let combinational outputs settle.
  task automatic issue(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [4:0] r0, input logic [4:0] r1);
    iss_valid = v;
    iss_we    = we;
    iss_load  = ld;
    iss_rd    = rd;
    iss_rs    = {r1, r0};
    flush     = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] op(input int i);
    return opnd[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] sel(input int i);
    return 32'(fwd_sel[i*SEL_W +: SEL_W]);
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_we = 1'b0; iss_load = 1'b0;
    iss_rd = '0; iss_rs = '0; rf_data = {RF1, RF0}; ex_data = '0; mem_data = '0;
    tick(); tick();

    // Reset state
    issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel0", sel(0), 32'd0);
    check("rst_opnd0", op(0), RF0);
    check("rst_sel1_r0", sel(1), 32'd4);
    check("rst_hits", 32'(fwd_hits), 32'd0);
    reset = 1'b0;
    tick();

    // 1: ADD r3 then SUB using r3 from EX
    issue(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2);
    check("t1_nomatch_sel0", sel(0), 32'd0);
    tick();
    ex_data = 32'h11;
    issue(1'b1, 1'b1, 1'b0, 5'd6, 5'd3, 5'd0);
    check("t1_opnd0", op(0), 32'h11);
    check("t1_sel0", sel(0), 32'd1);
    check("t1_opnd1_zero", op(1), 32'd0);
    check("t1_stall", 32'(stall), 32'd0);
    tick();
    ex_data = 32'h0;

    // 2: LW r4 then use -> one stall, then MEM forward
    check("t1_hits", 32'(fwd_hits), 32'd1);
    issue(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 1'b0, 5'd7, 5'd4, 5'd3);
    check("t2_stall", 32'(stall), 32'd1);
    tick();
    mem_data = 32'hDEAD;
    issue(1'b1, 1'b1, 1'b0, 5'd7, 5'd4, 5'd3);
    check("t2_stall_clr", 32'(stall), 32'd0);
    check("t2_opnd0", op(0), 32'hDEAD);
    check("t2_sel0", sel(0), 32'd2);
    check("t2_r3_retired_sel1", sel(1), 32'd0);
    check("t2_r3_retired_opnd1", op(1), RF1);
    check("t2_stall_cyc", 32'(stall_cyc), 32'd1);
    tick();
    check("t2_hits", 32'(fwd_hits), 32'd2);

    // 3: r5 in s[0] and s[2] -> youngest wins, both sources same stage
    issue(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
    tick();
    ex_data = 32'h22;
    issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
    tick();
    ex_data = 32'h33;
    issue(1'b1, 1'b1, 1'b0, 5'd8, 5'd5, 5'd5);
    check("t3_opnd0", op(0), 32'h33);
    check("t3_sel0", sel(0), 32'd1);
    check("t3_opnd1", op(1), 32'h33);
    check("t3_sel1", sel(1), 32'd1);
    tick();
    check("t3_hits", 32'(fwd_hits), 32'd4);

    // 4: r0 writer in flight is never forwarded
    issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    ex_data = 32'h55;
    issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("t4_opnd0", op(0), 32'd0);
    check("t4_sel0", sel(0), 32'd4);
    tick();
    check("t4_hits", 32'(fwd_hits), 32'd4);

    // 5a: flush with stall pending -> no stall, bubble enters s[0]
    issue(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    iss_valid = 1'b1; iss_we = 1'b1; iss_load = 1'b0; iss_rd = 5'd10;
    iss_rs = {5'd0, 5'd9}; flush = 1'b1;
    #1;
    check("t5_flush_stall", 32'(stall), 32'd0);
    tick();
    mem_data = 32'hBEEF;
    issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd10);
    check("t5_load_mem", op(0), 32'hBEEF);
    check("t5_load_sel", sel(0), 32'd2);
    check("t5_bubble_sel1", sel(1), 32'd0);
    check("t5_stall_cyc", 32'(stall_cyc), 32'd1);
    tick();

    // 5b: reset during a stall discards everything
    issue(1'b1, 1'b1, 1'b1, 5'd11, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 1'b0, 5'd12, 5'd11, 5'd12);
    check("t5_pre_rst_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_sel0", sel(0), 32'd0);
    check("t5_rst_sel1", sel(1), 32'd0);
    check("t5_rst_opnd0", op(0), RF0);
    check("t5_rst_hits", 32'(fwd_hits), 32'd0);
    check("t5_rst_stall_cyc", 32'(stall_cyc), 32'd0);
    tick();

    // 6: saturate fwd_hits at 4'hF
    issue(1'b1, 1'b1, 1'b0, 5'd13, 5'd0, 5'd0);
    tick();
    for (int i = 1; i <= 16; i++) begin
      ex_data = 32'(i);
      issue(1'b1, 1'b1, 1'b0, 5'd13, 5'd13, 5'd0);
      tick();
      if (i == 8) check("t6_hits_mid", 32'(fwd_hits), 32'd8);
    end
    check("t6_hits_sat", 32'(fwd_hits), 32'hF);
    issue(1'b1, 1'b1, 1'b0, 5'd13, 5'd13, 5'd13);
    tick();
    check("t6_hits_hold", 32'(fwd_hits), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
